ifu_fetch: RTL and testbench

Instruction fetch unit directly upstream of the single-cycle RV32I core. Takes the core's current PC, issues a read on the instruction-memory request/response port, and presents the fetched word on `ist` with a valid/ready handshake. Also drains in-flight responses after a redirect (`flush`) and flags misaligned or errored fetches.

---
 rtl/ifu_pkg.sv | 26 ++
 rtl/ifu_fetch_if.sv | 44 ++++
 rtl/ifu_perf_cnt.sv | 30 +++
 rtl/ifu_fetch.sv | 133 +++++++++++++
 tb/tb_ifu_fetch.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared definitions for the instruction fetch unit.
//   - ifu_state_e      : fetch FSM state encoding
//   - IFU_FAULT_INST   : instruction word presented with a misalignment fault
//   - IFU_ALIGN_MASK   : PC bits that must be zero for a legal fetch
//   - ifu_misaligned() : alignment check on the low PC bits
package ifu_pkg;

    localparam int IFU_ADDR_W = 32;
    localparam int IFU_DATA_W = 32;

    localparam logic [31:0] IFU_FAULT_INST = 32'h0;
    localparam logic [1:0]  IFU_ALIGN_MASK = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } ifu_state_e;

    function automatic logic ifu_misaligned(input logic [1:0] pc_lsb);
        return (pc_lsb & IFU_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: all non-clock signals of the fetch unit.
//   core side   : pc, pc_valid, flush, ist, ist_valid, ist_ready, ist_fault
//   memory side : imem_req_valid/ready/addr, imem_rsp_valid/data/err
//   perf        : perf_fetch_cnt, perf_stall_cnt
// modport master : the fetch unit itself; modport slave : core + memory side.
interface ifu_fetch_if
    import ifu_pkg::*;
#(
    parameter int ADDR_W = IFU_ADDR_W,
    parameter int DATA_W = IFU_DATA_W
);
    logic [ADDR_W-1:0] pc;
    logic              pc_valid;
    logic              flush;
    logic [DATA_W-1:0] ist;
    logic              ist_valid;
    logic              ist_ready;
    logic              ist_fault;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [DATA_W-1:0] imem_rsp_data;
    logic              imem_rsp_err;
    logic [31:0]       perf_fetch_cnt;
    logic [31:0]       perf_stall_cnt;

    modport master (
        input  pc, pc_valid, flush, ist_ready,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output ist, ist_valid, ist_fault,
        output imem_req_valid, imem_req_addr,
        output perf_fetch_cnt, perf_stall_cnt
    );

    modport slave (
        output pc, pc_valid, flush, ist_ready,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  ist, ist_valid, ist_fault,
        input  imem_req_valid, imem_req_addr,
        input  perf_fetch_cnt, perf_stall_cnt
    );

endinterface

// File: rtl/ifu_perf_cnt.sv
// ifu_perf_cnt: two free-running 32-bit event counters, wrapping mod 2^32.
//   clk, reset (async, active low)
//   fetch_inc_i / stall_inc_i : increment enables
//   fetch_cnt_o / stall_cnt_o : registered counts
module ifu_perf_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_inc_i,
    input  logic        stall_inc_i,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] stall_cnt_o
);

    logic [31:0] fetch_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_q <= '0;
            stall_q <= '0;
        end else begin
            if (fetch_inc_i) fetch_q <= fetch_q + 32'd1;
            if (stall_inc_i) stall_q <= stall_q + 32'd1;
        end
    end

    assign fetch_cnt_o = fetch_q;
    assign stall_cnt_o = stall_q;

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit in front of the RV32I core.
//   clk   : clock, all state on the rising edge
//   reset : asynchronous, active-low reset
//   bus   : ifu_fetch_if.master (core handshake, imem req/rsp, perf counters)
// Build option: IFU_PERF_CNT_EN instantiates ifu_perf_cnt; without it both
// perf outputs are tied to zero.
//
// state | meaning
// IDLE  | no fetch in progress, waiting for pc_valid
// REQ   | request presented on imem, waiting for imem_req_ready
// WAIT  | request accepted, waiting for the response
// HOLD  | instruction (or fault) presented on ist until consumed or flushed
// DROP  | accepted request was flushed; swallow its response
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int ADDR_W = IFU_ADDR_W,
    parameter int DATA_W = IFU_DATA_W
) (
    input  logic         clk,
    input  logic         reset,
    ifu_fetch_if.master  bus
);

    ifu_state_e        state_q;
    logic [DATA_W-1:0] ist_q;
    logic              ist_valid_q;
    logic              ist_fault_q;
    logic              req_valid_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic              flush_seen_q;

    // A new PC is taken from IDLE, or from HOLD when the held word is consumed.
    logic accept_pc;
    logic pc_bad;

    assign accept_pc = bus.pc_valid &&
                       ((state_q == IDLE) ||
                        (state_q == HOLD && !bus.flush && bus.ist_ready));
    assign pc_bad    = ifu_misaligned(bus.pc[1:0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ist_q        <= '0;
            ist_valid_q  <= 1'b0;
            ist_fault_q  <= 1'b0;
            req_valid_q  <= 1'b0;
            req_addr_q   <= '0;
            flush_seen_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                REQ: begin
                    // A flush here cannot cancel the handshake; remember it so
                    // the response is discarded instead.
                    if (bus.flush) flush_seen_q <= 1'b1;
                    if (bus.imem_req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= (flush_seen_q || bus.flush) ? DROP : WAIT;
                    end
                end
                WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        if (bus.flush) begin
                            state_q <= IDLE;
                        end else begin
                            ist_q       <= bus.imem_rsp_data;
                            ist_fault_q <= bus.imem_rsp_err;
                            ist_valid_q <= 1'b1;
                            state_q     <= HOLD;
                        end
                    end else if (bus.flush) begin
                        state_q <= DROP;
                    end
                end
                HOLD: begin
                    if (bus.flush || bus.ist_ready) begin
                        ist_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                DROP: begin
                    if (bus.imem_rsp_valid) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            // Overrides the IDLE/HOLD outcome above when a new fetch starts.
            if (accept_pc) begin
                if (pc_bad) begin
                    ist_q       <= IFU_FAULT_INST;
                    ist_fault_q <= 1'b1;
                    ist_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end else begin
                    req_valid_q  <= 1'b1;
                    req_addr_q   <= {bus.pc[ADDR_W-1:2], 2'b00};
                    flush_seen_q <= 1'b0;
                    ist_valid_q  <= 1'b0;
                    state_q      <= REQ;
                end
            end
        end
    end

    assign bus.ist            = ist_q;
    assign bus.ist_valid      = ist_valid_q;
    assign bus.ist_fault      = ist_fault_q;
    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_req_addr  = req_addr_q;

`ifdef IFU_PERF_CNT_EN
    logic fetch_inc;
    logic stall_inc;

    assign fetch_inc = (state_q == HOLD) && !bus.flush && bus.ist_ready;
    assign stall_inc = (state_q == REQ) || (state_q == WAIT);

    ifu_perf_cnt u_perf_cnt (
        .clk         (clk),
        .reset       (reset),
        .fetch_inc_i (fetch_inc),
        .stall_inc_i (stall_inc),
        .fetch_cnt_o (bus.perf_fetch_cnt),
        .stall_cnt_o (bus.perf_stall_cnt)
    );
`else
    assign bus.perf_fetch_cnt = '0;
    assign bus.perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;
    import ifu_pkg::*;

`ifdef IFU_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    ifu_fetch_if bus ();

    ifu_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: what the core and memory must observe.
    bit          m_req, m_out, m_drop, m_fpend, m_hold, m_fault;
    logic [31:0] m_addr, m_ist;
    int unsigned m_fetch, m_stall;

    always @(posedge clk or negedge reset) begin : model
        bit launch;
        if (!reset) begin
            m_req = 0; m_out = 0; m_drop = 0; m_fpend = 0; m_hold = 0; m_fault = 0;
            m_addr = 0; m_ist = 0; m_fetch = 0; m_stall = 0;
        end else begin
            launch = 0;
            if (m_req || (m_out && !m_drop)) m_stall++;
            if (m_req) begin
                if (bus.flush) m_fpend = 1;
                if (bus.imem_req_ready) begin
                    m_req = 0; m_out = 1; m_drop = m_fpend;
                end
            end else if (m_out) begin
                if (bus.imem_rsp_valid) begin
                    m_out = 0;
                    if (!m_drop && !bus.flush) begin
                        m_hold = 1; m_ist = bus.imem_rsp_data; m_fault = bus.imem_rsp_err;
                    end
                end else if (bus.flush) begin
                    m_drop = 1;
                end
            end else if (m_hold) begin
                if (bus.flush) m_hold = 0;
                else if (bus.ist_ready) begin
                    m_hold = 0; m_fetch++; launch = bus.pc_valid;
                end
            end else begin
                launch = bus.pc_valid;
            end
            if (launch) begin
                if (bus.pc % 4 != 0) begin
                    m_hold = 1; m_ist = 32'h0; m_fault = 1;
                end else begin
                    m_req = 1; m_addr = bus.pc; m_fpend = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("ist_valid", {31'b0, bus.ist_valid}, {31'b0, m_hold});
            chk("req_valid", {31'b0, bus.imem_req_valid}, {31'b0, m_req});
            if (m_req) chk("req_addr", bus.imem_req_addr, m_addr);
            if (m_hold) begin
                chk("ist", bus.ist, m_ist);
                chk("ist_fault", {31'b0, bus.ist_fault}, {31'b0, m_fault});
            end
            chk("perf_fetch", bus.perf_fetch_cnt, PERF ? m_fetch : 32'd0);
            chk("perf_stall", bus.perf_stall_cnt, PERF ? m_stall : 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    // Fetch an aligned address with ready=1, response one cycle after accept.
    task automatic fetch_to_hold(input logic [31:0] addr, input logic [31:0] data, input logic err);
        bus.pc = addr; bus.pc_valid = 1; bus.imem_req_ready = 1;
        step();
        bus.pc_valid = 0;
        step();
        bus.imem_rsp_valid = 1; bus.imem_rsp_data = data; bus.imem_rsp_err = err;
        step();
        bus.imem_rsp_valid = 0; bus.imem_rsp_err = 0;
    endtask

    task automatic consume();
        bus.ist_ready = 1;
        step();
        bus.ist_ready = 0;
    endtask

    initial begin
        bus.pc = 0; bus.pc_valid = 0; bus.flush = 0; bus.ist_ready = 0;
        bus.imem_req_ready = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = 0; bus.imem_rsp_err = 0;
        reset = 1'b0;
        #12;
        chk("rst ist", bus.ist, 32'h0);
        chk("rst ist_valid", {31'b0, bus.ist_valid}, 32'd0);
        chk("rst ist_fault", {31'b0, bus.ist_fault}, 32'd0);
        chk("rst req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        chk("rst req_addr", bus.imem_req_addr, 32'h0);
        chk("rst perf_fetch", bus.perf_fetch_cnt, 32'd0);
        chk("rst perf_stall", bus.perf_stall_cnt, 32'd0);
        step();
        reset = 1'b1;
        step();

        // Aligned fetch, minimum latency.
        bus.pc = 32'h8000_0000; bus.pc_valid = 1; bus.imem_req_ready = 1;
        step();
        bus.pc_valid = 0;
        chk("lat c1 req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        chk("lat c1 req_addr", bus.imem_req_addr, 32'h8000_0000);
        step();
        chk("lat c2 req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        bus.imem_rsp_valid = 1; bus.imem_rsp_data = 32'h0010_0093;
        step();
        bus.imem_rsp_valid = 0;
        chk("lat c3 ist_valid", {31'b0, bus.ist_valid}, 32'd1);
        chk("lat c3 ist", bus.ist, 32'h0010_0093);
        chk("lat c3 ist_fault", {31'b0, bus.ist_fault}, 32'd0);
        consume();

        // Backpressure: request held 4 cycles.
        do_reset();
        step();
        bus.pc = 32'h8000_0010; bus.pc_valid = 1; bus.imem_req_ready = 0;
        step();
        bus.pc_valid = 0;
        for (int i = 0; i < 4; i++) begin
            chk("bp req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
            chk("bp req_addr", bus.imem_req_addr, 32'h8000_0010);
            step();
        end
        bus.imem_req_ready = 1;
        chk("bp last req_addr", bus.imem_req_addr, 32'h8000_0010);
        step();
        bus.imem_rsp_valid = 1; bus.imem_rsp_data = 32'h00A0_0113;
        chk("bp perf_stall", bus.perf_stall_cnt, PERF ? 32'd5 : 32'd0);
        step();
        bus.imem_rsp_valid = 0;
        chk("bp ist", bus.ist, 32'h00A0_0113);
        consume();
        chk("bp perf_fetch", bus.perf_fetch_cnt, PERF ? 32'd1 : 32'd0);

        // Misaligned fetch: fault one cycle later, no memory request.
        bus.pc = 32'h8000_0002; bus.pc_valid = 1;
        step();
        bus.pc_valid = 0;
        chk("mis req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        chk("mis ist_valid", {31'b0, bus.ist_valid}, 32'd1);
        chk("mis ist_fault", {31'b0, bus.ist_fault}, 32'd1);
        chk("mis ist", bus.ist, 32'h0);
        consume();

        // Flush in WAIT, late response dropped, then a normal fetch.
        bus.pc = 32'h8000_0020; bus.pc_valid = 1;
        step();
        bus.pc_valid = 0;
        step();
        bus.flush = 1;
        step();
        bus.flush = 0;
        step();
        bus.imem_rsp_valid = 1; bus.imem_rsp_data = 32'hDEAD_BEEF;
        step();
        bus.imem_rsp_valid = 0;
        chk("flw ist_valid", {31'b0, bus.ist_valid}, 32'd0);
        step();
        chk("flw ist_valid2", {31'b0, bus.ist_valid}, 32'd0);
        fetch_to_hold(32'h8000_0004, 32'h0020_8133, 1'b0);
        chk("flw refetch ist", bus.ist, 32'h0020_8133);
        consume();

        // Error response held under core backpressure.
        fetch_to_hold(32'h8000_0030, 32'h1234_5678, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("err ist_fault", {31'b0, bus.ist_fault}, 32'd1);
            chk("err ist", bus.ist, 32'h1234_5678);
            step();
        end
        consume();
        chk("err released", {31'b0, bus.ist_valid}, 32'd0);

        // Back-to-back fetches: one instruction every 3 cycles.
        fetch_to_hold(32'h8000_0040, 32'h0000_0013, 1'b0);
        bus.pc = 32'h8000_0044; bus.pc_valid = 1; bus.ist_ready = 1;
        step();
        bus.pc_valid = 0; bus.ist_ready = 0;
        chk("b2b req_addr", bus.imem_req_addr, 32'h8000_0044);
        step();
        bus.imem_rsp_valid = 1; bus.imem_rsp_data = 32'h0000_0033;
        step();
        bus.imem_rsp_valid = 0;
        chk("b2b ist", bus.ist, 32'h0000_0033);
        // Flush beats ist_ready in HOLD.
        bus.flush = 1; bus.ist_ready = 1;
        step();
        bus.flush = 0; bus.ist_ready = 0;
        chk("hold flush", {31'b0, bus.ist_valid}, 32'd0);

        // Flush in REQ: handshake completes, response swallowed.
        // Flush together with pc_valid in IDLE still starts the fetch.
        bus.pc = 32'h8000_0050; bus.pc_valid = 1; bus.flush = 1; bus.imem_req_ready = 0;
        step();
        bus.pc_valid = 0;
        chk("idle flush+pc", {31'b0, bus.imem_req_valid}, 32'd1);
        step();
        bus.flush = 0; bus.imem_req_ready = 1;
        step();
        bus.imem_rsp_valid = 1; bus.imem_rsp_data = 32'h5555_5555;
        step();
        bus.imem_rsp_valid = 0;
        chk("req flush", {31'b0, bus.ist_valid}, 32'd0);
        // Flush coinciding with the response in WAIT, then a stray response.
        bus.pc = 32'h8000_0060; bus.pc_valid = 1;
        step();
        bus.pc_valid = 0;
        step();
        bus.imem_rsp_valid = 1; bus.flush = 1;
        step();
        bus.flush = 0;
        step();
        bus.imem_rsp_valid = 0;
        chk("stray rsp", {31'b0, bus.ist_valid}, 32'd0);

        // Async reset in WAIT, then a late response.
        bus.pc = 32'h8000_0070; bus.pc_valid = 1;
        step();
        bus.pc_valid = 0;
        step();
        #2 reset = 1'b0;
        #1;
        chk("areset state addr", bus.imem_req_addr, 32'h0);
        chk("areset req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        chk("areset ist_valid", {31'b0, bus.ist_valid}, 32'd0);
        chk("areset perf_stall", bus.perf_stall_cnt, 32'd0);
        step();
        reset = 1'b1;
        bus.imem_rsp_valid = 1; bus.imem_rsp_data = 32'hCAFE_F00D;
        step();
        bus.imem_rsp_valid = 0;
        chk("late rsp ignored", {31'b0, bus.ist_valid}, 32'd0);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
